stride_read_master: RTL and testbench

STRIDE_READ_MASTER -- requirements
Module: stride_read_master

---
 rtl/prefetcher_pkg.sv | 18 +
 rtl/srm_len_fifo.sv | 76 +++++++
 rtl/stride_read_master.sv | 236 +++++++++++++++++++++++
 tb/tb_stride_read_master.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetcher_pkg.sv
// Types and defaults shared by the stride read master and the other prefetcher blocks.
package prefetcher_pkg;

    typedef enum logic [1:0] {
        SRM_IDLE  = 2'd0,
        SRM_ISSUE = 2'd1,
        SRM_DRAIN = 2'd2,
        SRM_DONE  = 2'd3
    } srm_state_t;

    localparam int SRM_DEF_LOG_MAX_OUTSTANDING = 2;
    localparam int SRM_DEF_MAX_OUTSTANDING     = 32'sd1 << SRM_DEF_LOG_MAX_OUTSTANDING;

    function automatic int srm_max_outstanding(input int log_max);
        return 32'sd1 << log_max;
    endfunction

endpackage

// File: rtl/srm_len_fifo.sv
// Per-burst expected-length FIFO for the stride read master's response checker.
// Only compiled when STRIDE_READ_MASTER_CHECK_EN is defined.
`ifdef STRIDE_READ_MASTER_CHECK_EN
module srm_len_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PW'(DEPTH - 1)) begin
            nxt = {PW{1'b0}};
        end else begin
            nxt = ptr + PW'(1);
        end
        return nxt;
    endfunction

    assign w_do_pop  = pop && (r_count != {CW{1'b0}});
    assign w_do_push = push && ((r_count != CW'(DEPTH)) || w_do_pop);
    assign empty     = (r_count == {CW{1'b0}});
    assign dout      = r_mem[r_rd_ptr];

    // Storage needs no reset: only entries below r_count are ever read
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (clr) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`endif

// File: rtl/stride_read_master.sv
// Strided AR-burst read master: issues num_reqs bursts at base + k*stride and drains the responses.
// Define STRIDE_READ_MASTER_CHECK_EN to add the response ID/last checker driving error.
module stride_read_master
    import prefetcher_pkg::*;
#(
    parameter int ADDR_BITS            = 64,
    parameter int BURST_LEN_WIDTH      = 8,
    parameter int TID_WIDTH            = 8,
    parameter int LOG_BLOCK_DATA_BYTES = 0,
    parameter int LOG_MAX_OUTSTANDING  = SRM_DEF_LOG_MAX_OUTSTANDING
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [ADDR_BITS-1:0]                  base_addr,
    input  logic [ADDR_BITS-1:0]                  stride,
    input  logic [15:0]                           num_reqs,
    input  logic [BURST_LEN_WIDTH-1:0]            burst_len,
    input  logic [TID_WIDTH-1:0]                  req_id,
    output logic                                  m_ar_valid,
    input  logic                                  m_ar_ready,
    output logic [ADDR_BITS-1:0]                  m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0]            m_ar_len,
    output logic [TID_WIDTH-1:0]                  m_ar_id,
    input  logic                                  m_r_valid,
    output logic                                  m_r_ready,
    input  logic                                  m_r_last,
    input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  m_r_data,
    input  logic [TID_WIDTH-1:0]                  m_r_id,
    output logic                                  busy,
    output logic                                  done,
    output logic [15:0]                           reqs_issued,
    output logic [31:0]                           beats_rcvd,
    output logic                                  error
);

    localparam int OW = LOG_MAX_OUTSTANDING + 1;
    localparam logic [OW-1:0] MAX_OUT = OW'(srm_max_outstanding(LOG_MAX_OUTSTANDING));

    srm_state_t                 r_state;
    srm_state_t                 w_state_nxt;
    logic [ADDR_BITS-1:0]       r_addr;
    logic [ADDR_BITS-1:0]       r_stride;
    logic [15:0]                r_num_reqs;
    logic [BURST_LEN_WIDTH-1:0] r_len;
    logic [TID_WIDTH-1:0]       r_id;
    logic [15:0]                r_reqs_issued;
    logic [31:0]                r_beats_rcvd;
    logic [OW-1:0]              r_outstanding;

    logic w_start_acc;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_r_last_hs;
    logic w_out_dec;
    logic w_last_req;
    logic w_unused;

    assign w_start_acc = (r_state == SRM_IDLE) && start;
    assign w_ar_hs     = m_ar_valid && m_ar_ready;
    assign w_r_hs      = m_r_valid && m_r_ready;
    assign w_r_last_hs = w_r_hs && m_r_last;
    // A stray last with nothing outstanding must not wrap the counter
    assign w_out_dec   = w_r_last_hs && (r_outstanding != {OW{1'b0}});
    assign w_last_req  = ((r_reqs_issued + 16'd1) == r_num_reqs);
    assign w_unused    = ^{m_r_data, m_r_id};

    assign m_ar_addr   = r_addr;
    assign m_ar_len    = r_len;
    assign m_ar_id     = r_id;
    assign reqs_issued = r_reqs_issued;
    assign beats_rcvd  = r_beats_rcvd;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SRM_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SRM_IDLE: begin
                if (start) begin
                    w_state_nxt = (num_reqs == 16'd0) ? SRM_DONE : SRM_ISSUE;
                end else begin
                    w_state_nxt = SRM_IDLE;
                end
            end
            SRM_ISSUE: begin
                if (w_ar_hs && w_last_req) begin
                    w_state_nxt = SRM_DRAIN;
                end else begin
                    w_state_nxt = SRM_ISSUE;
                end
            end
            SRM_DRAIN: begin
                if (r_outstanding == {OW{1'b0}}) begin
                    w_state_nxt = SRM_DONE;
                end else begin
                    w_state_nxt = SRM_DRAIN;
                end
            end
            SRM_DONE: w_state_nxt = SRM_IDLE;
            default:  w_state_nxt = SRM_IDLE;
        endcase
    end

    // Output decode; AR valid can only fall through a handshake since outstanding only drops otherwise
    always_comb begin
        m_ar_valid = 1'b0;
        m_r_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            SRM_ISSUE: begin
                m_ar_valid = (r_outstanding < MAX_OUT);
                m_r_ready  = 1'b1;
                busy       = 1'b1;
            end
            SRM_DRAIN: begin
                m_r_ready  = 1'b1;
                busy       = 1'b1;
            end
            SRM_DONE: begin
                done       = 1'b1;
            end
            default: begin
                m_ar_valid = 1'b0;
            end
        endcase
    end

    // Job configuration, progress counters and outstanding-burst count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr        <= {ADDR_BITS{1'b0}};
            r_stride      <= {ADDR_BITS{1'b0}};
            r_num_reqs    <= 16'd0;
            r_len         <= {BURST_LEN_WIDTH{1'b0}};
            r_id          <= {TID_WIDTH{1'b0}};
            r_reqs_issued <= 16'd0;
            r_beats_rcvd  <= 32'd0;
            r_outstanding <= {OW{1'b0}};
        end else if (w_start_acc) begin
            r_addr        <= base_addr;
            r_stride      <= stride;
            r_num_reqs    <= num_reqs;
            r_len         <= burst_len;
            r_id          <= req_id;
            r_reqs_issued <= 16'd0;
            r_beats_rcvd  <= 32'd0;
            r_outstanding <= {OW{1'b0}};
        end else begin
            if (w_ar_hs) begin
                r_reqs_issued <= r_reqs_issued + 16'd1;
                r_addr        <= r_addr + r_stride;
            end
            if (w_r_hs) begin
                r_beats_rcvd <= r_beats_rcvd + 32'd1;
            end
            case ({w_ar_hs, w_out_dec})
                2'b10:   r_outstanding <= r_outstanding + OW'(1);
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

`ifdef STRIDE_READ_MASTER_CHECK_EN
    logic [BURST_LEN_WIDTH-1:0] w_exp_len;
    logic                       w_fifo_empty;
    logic [BURST_LEN_WIDTH-1:0] r_beat;
    logic                       r_error;
    logic                       w_chk_err;

    srm_len_fifo #(
        .DEPTH (1 << LOG_MAX_OUTSTANDING),
        .WIDTH (BURST_LEN_WIDTH)
    ) u_len_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_start_acc),
        .push  (w_ar_hs),
        .din   (r_len),
        .pop   (w_r_last_hs),
        .dout  (w_exp_len),
        .empty (w_fifo_empty)
    );

    // A beat is bad if its ID is foreign, nothing is pending, or last disagrees with the beat index
    always_comb begin
        w_chk_err = 1'b0;
        if (w_r_hs) begin
            w_chk_err = (m_r_id != r_id) || w_fifo_empty || (m_r_last != (r_beat == w_exp_len));
        end else begin
            w_chk_err = 1'b0;
        end
    end

    // Beat index within the current response burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat <= {BURST_LEN_WIDTH{1'b0}};
        end else if (w_start_acc) begin
            r_beat <= {BURST_LEN_WIDTH{1'b0}};
        end else if (w_r_hs) begin
            r_beat <= m_r_last ? {BURST_LEN_WIDTH{1'b0}} : (r_beat + BURST_LEN_WIDTH'(1));
        end else begin
            r_beat <= r_beat;
        end
    end

    // Sticky error flag, cleared by the next accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error <= 1'b0;
        end else if (w_start_acc) begin
            r_error <= 1'b0;
        end else if (w_chk_err) begin
            r_error <= 1'b1;
        end else begin
            r_error <= r_error;
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_stride_read_master.sv
// Randomised scoreboard bench for stride_read_master with a behavioural memory stub.
module tb_stride_read_master;

`ifdef STRIDE_READ_MASTER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int MAXO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start;
    logic [63:0] base_addr, stride;
    logic [15:0] num_reqs;
    logic [7:0]  burst_len, req_id;
    logic        m_ar_valid, m_ar_ready;
    logic [63:0] m_ar_addr;
    logic [7:0]  m_ar_len, m_ar_id;
    logic        m_r_valid, m_r_ready, m_r_last;
    logic [7:0]  m_r_data, m_r_id;
    logic        busy, done, error;
    logic [15:0] reqs_issued;
    logic [31:0] beats_rcvd;

    stride_read_master dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stride(stride),
        .num_reqs(num_reqs), .burst_len(burst_len), .req_id(req_id),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last),
        .m_r_data(m_r_data), .m_r_id(m_r_id),
        .busy(busy), .done(done), .reqs_issued(reqs_issued), .beats_rcvd(beats_rcvd),
        .error(error)
    );

    typedef struct { logic [63:0] addr; logic [7:0] len; logic [7:0] id; } ar_exp_t;
    typedef struct { int n; int beats; bit err; } done_exp_t;
    typedef struct { logic [7:0] len; logic [7:0] id; } burst_t;

    ar_exp_t   exp_ar[$];
    done_exp_t exp_done[$];
    burst_t    pend[$];

    int n_cmp = 0, n_bad = 0;
    int ar_count = 0, done_cnt = 0, jobs_issued = 0, stall_cnt = 0;
    int ar_mode = 0;
    bit mem_en = 1'b1, inject_arm = 1'b0, stub_inj = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    // Memory stub: accepts ARs per ar_mode, returns len+1 beats per burst in order with random gaps
    initial begin : mem_stub
        bit ar_f, r_f, r_l;
        logic [7:0] a_len, a_id;
        int beat;
        beat = 0;
        m_ar_ready = 1'b0; m_r_valid = 1'b0; m_r_last = 1'b0; m_r_data = 8'h00; m_r_id = 8'h00;
        forever begin
            @(negedge clk);
            ar_f = m_ar_valid && m_ar_ready;
            r_f = m_r_valid && m_r_ready;
            r_l = m_r_last;
            a_len = m_ar_len;
            a_id = m_ar_id;
            @(posedge clk);
            #1;
            if (rst) begin
                pend.delete();
                beat = 0;
                m_r_valid = 1'b0;
                m_r_last = 1'b0;
                stub_inj = 1'b0;
            end else begin
                if (ar_f) pend.push_back('{a_len, a_id});
                if (r_f && pend.size() > 0) begin
                    if (r_l) begin
                        pend.delete(0);
                        beat = 0;
                    end else begin
                        beat++;
                    end
                end
                stub_inj = 1'b0;
                if (mem_en && pend.size() > 0 && ($urandom % 4 != 0)) begin
                    m_r_valid = 1'b1;
                    m_r_id = pend[0].id;
                    m_r_data = 8'($urandom);
                    m_r_last = (beat == int'(pend[0].len));
                    if (inject_arm && beat == 1) begin
                        m_r_last = 1'b1;
                        stub_inj = 1'b1;
                        inject_arm = 1'b0;
                    end
                end else begin
                    m_r_valid = 1'b0;
                    m_r_last = 1'b0;
                end
            end
            m_ar_ready = (ar_mode == 0) ? 1'b1 : (ar_mode == 1) ? ($urandom % 3 != 0) : 1'b0;
        end
    end

    // Monitor: pops expected ARs and completions, checks hold/cap rules and error timing
    initial begin : monitor
        bit prev_stall, prev_inj, prev_done;
        logic [63:0] h_addr;
        logic [7:0] h_len, h_id;
        int model_out;
        ar_exp_t ea;
        done_exp_t ed;
        prev_stall = 1'b0; prev_inj = 1'b0; prev_done = 1'b0; model_out = 0;
        h_addr = 64'd0; h_len = 8'd0; h_id = 8'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_out = 0; prev_stall = 1'b0; prev_inj = 1'b0; prev_done = 1'b0;
            end else begin
                if (prev_inj) chk("error_after_early_last", error, CHK);
                if (prev_stall) begin
                    chk("ar_valid_held", m_ar_valid, 1);
                    chk("ar_addr_held", m_ar_addr, h_addr);
                    chk("ar_len_held", m_ar_len, h_len);
                    chk("ar_id_held", m_ar_id, h_id);
                end
                if (model_out >= MAXO) chk("ar_valid_at_max", m_ar_valid, 0);
                if (m_ar_valid && m_ar_ready) begin
                    ar_count++;
                    if (exp_ar.size() == 0) begin
                        fail_evt("ar_unexpected");
                    end else begin
                        ea = exp_ar.pop_front();
                        chk("ar_addr", m_ar_addr, ea.addr);
                        chk("ar_len", m_ar_len, ea.len);
                        chk("ar_id", m_ar_id, ea.id);
                    end
                end
                if (done) begin
                    chk("done_single_cycle", prev_done, 0);
                    done_cnt++;
                    if (exp_done.size() == 0) begin
                        fail_evt("done_unexpected");
                    end else begin
                        ed = exp_done.pop_front();
                        chk("done_reqs_issued", reqs_issued, ed.n);
                        chk("done_beats_rcvd", beats_rcvd, ed.beats);
                        chk("done_error", error, ed.err);
                    end
                end
                if (m_ar_valid && !m_ar_ready) stall_cnt++;
                model_out = model_out + ((m_ar_valid && m_ar_ready) ? 1 : 0)
                                      - ((m_r_valid && m_r_ready && m_r_last) ? 1 : 0);
                prev_stall = m_ar_valid && !m_ar_ready;
                h_addr = m_ar_addr; h_len = m_ar_len; h_id = m_ar_id;
                prev_inj = m_r_valid && m_r_ready && stub_inj;
                prev_done = done;
            end
        end
    end

    task automatic issue_job(input logic [63:0] b, input logic [63:0] s, input int n,
                             input int len, input logic [7:0] id, input bit inj);
        ar_exp_t ea;
        done_exp_t ed;
        @(posedge clk);
        #1;
        base_addr = b; stride = s; num_reqs = 16'(n); burst_len = 8'(len); req_id = id;
        start = 1'b1;
        for (int k = 0; k < n; k++) begin
            ea.addr = b + 64'(k) * s;
            ea.len = 8'(len);
            ea.id = id;
            exp_ar.push_back(ea);
        end
        ed.n = n;
        ed.beats = n * (len + 1) - (inj ? (len - 1) : 0);
        ed.err = CHK && inj;
        exp_done.push_back(ed);
        inject_arm = inj;
        jobs_issued++;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (done_cnt < jobs_issued && c < 5000) begin
            @(posedge clk);
            c++;
        end
        chk("job_completes", (done_cnt >= jobs_issued) ? 64'd1 : 64'd0, 1);
    endtask

    initial begin : main
        int a0, s0;
        rst = 1'b1; start = 1'b0; base_addr = 64'd0; stride = 64'd0;
        num_reqs = 16'd0; burst_len = 8'd0; req_id = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ar_valid", m_ar_valid, 0);
        chk("rst_r_ready", m_r_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_reqs_issued", reqs_issued, 0);
        chk("rst_beats_rcvd", beats_rcvd, 0);
        rst = 1'b0;

        // Basic strided job with an always-ready slave
        issue_job(64'h0000_0000_dead_beef, 64'h40, 4, 3, 8'h11, 1'b0);
        wait_done();

        // AR held back for several cycles
        ar_mode = 2;
        s0 = stall_cnt;
        issue_job(64'h1000, 64'h80, 3, 1, 8'h22, 1'b0);
        repeat (8) @(posedge clk);
        chk("ar_stall_cycles", (stall_cnt - s0 >= 5) ? 64'd1 : 64'd0, 1);
        ar_mode = 0;
        wait_done();

        // Silent memory: issue must cap at the outstanding limit
        mem_en = 1'b0;
        a0 = ar_count;
        issue_job(64'h2000, 64'h20, 8, 1, 8'h33, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        chk("cap_ar_count", ar_count - a0, MAXO);
        chk("cap_ar_valid", m_ar_valid, 0);
        mem_en = 1'b1;
        wait_done();

        // Address wrap past the top of the space
        issue_job(64'hFFFF_FFFF_FFFF_FFC0, 64'h40, 2, 0, 8'h44, 1'b0);
        wait_done();

        // Zero-request job completes immediately
        issue_job(64'h3000, 64'h10, 0, 2, 8'h55, 1'b0);
        wait_done();

        // Start while busy must be ignored
        ar_mode = 1;
        fork
            begin
                repeat (8) @(posedge clk);
                #2;
                start = 1'b1;
                base_addr = 64'h0000_0000_1234_0000;
                num_reqs = 16'd1;
                @(posedge clk);
                #2;
                start = 1'b0;
            end
        join_none
        issue_job(64'h4000, 64'h100, 10, 3, 8'h5a, 1'b0);
        wait_done();

        // Early last on beat 1, then a clean job clears the error
        issue_job(64'h5000, 64'h40, 3, 3, 8'h66, 1'b1);
        wait_done();
        issue_job(64'h6000, 64'h40, 2, 2, 8'h77, 1'b0);
        wait_done();

        // Reset while draining two outstanding bursts
        ar_mode = 0;
        mem_en = 1'b0;
        a0 = ar_count;
        issue_job(64'h7000, 64'h40, 2, 3, 8'h88, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("drain_ar_count", ar_count - a0, 2);
        chk("drain_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ar_valid", m_ar_valid, 0);
        chk("mid_rst_r_ready", m_r_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_reqs_issued", reqs_issued, 0);
        chk("mid_rst_beats_rcvd", beats_rcvd, 0);
        exp_ar.delete();
        exp_done.delete();
        jobs_issued = done_cnt;
        inject_arm = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_en = 1'b1;
        issue_job(64'h8000, 64'h40, 3, 2, 8'h99, 1'b0);
        wait_done();

        // Random jobs
        ar_mode = 1;
        for (int j = 0; j < 8; j++) begin
            issue_job({$urandom, $urandom}, (j % 2 == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 4096)),
                      $urandom_range(1, 12), $urandom_range(0, 7), 8'($urandom), 1'b0);
            wait_done();
        end

        repeat (5) @(posedge clk);
        chk("all_ars_consumed", exp_ar.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
